// File: rtl/cube_calc.sv
// rtl/cube_calc.sv - sequential unsigned cube unit (y = a^3) built around one shared shift-add multiplier
module cube_calc #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic [3*WIDTH-1:0] y_bo
);
    localparam int RW = 3 * WIDTH;
    localparam int SW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        CUBE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [SW-1:0]   sq_q, sq_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   y_q, y_d;

    logic [RW-1:0]   mcand;
    logic [RW-1:0]   partial;
    logic [RW-1:0]   acc_sum;
    logic            last_step;

    // The multiplier bit always comes from op_a; only the multiplicand switches between a and a*a.
    always_comb begin
        mcand     = (state_q == CUBE) ? {{WIDTH{1'b0}}, sq_q} : {{SW{1'b0}}, op_a_q};
        partial   = op_a_q[cnt_q] ? (mcand << cnt_q) : '0;
        acc_sum   = acc_q + partial;
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        acc_d   = acc_q;
        sq_d    = sq_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_a_d  = a_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SQ;
                end
            end
            SQ: begin
                if (last_step) begin
                    sq_d    = acc_sum[SW-1:0];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CUBE;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CUBE: begin
                if (last_step) begin
                    y_d     = acc_sum;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            acc_q   <= '0;
            sq_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            acc_q   <= acc_d;
            sq_q    <= sq_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign y_bo   = y_q;
endmodule

// File: tb/tb_cube_calc.sv
// tb/tb_cube_calc.sv - randomized and directed self-checking bench for cube_calc
module tb_cube_calc;
    localparam int WIDTH = 8;
    localparam int LAT   = 2 * WIDTH;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   a;
    logic               start;
    logic               busy;
    logic [3*WIDTH-1:0] y;

    int n_checks = 0;
    int n_fail   = 0;

    cube_calc #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .a_i    (a),
        .start_i(start),
        .busy_o (busy),
        .y_bo   (y)
    );

    always #5 clk = ~clk;

    function automatic longint cube_model(input longint v);
        return v * v * v;
    endfunction

    function automatic longint cbrt_model(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Launches one operation from idle and measures it; glitch_cyc >= 1 pulses start with glitch_a mid-run.
    task automatic run_op(input logic [WIDTH-1:0] av, input int glitch_cyc, input logic [WIDTH-1:0] glitch_a,
                          output int busy_cycles, output bit y_moved, output logic [3*WIDTH-1:0] y_final);
        logic [3*WIDTH-1:0] y_start;
        @(negedge clk);
        a = av; start = 1'b1;
        y_start = y;
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        busy_cycles = 0;
        y_moved = 1'b0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            if (y !== y_start) y_moved = 1'b1;
            if (busy_cycles == glitch_cyc) begin start = 1'b1; a = glitch_a; end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        y_final = y;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_checks++;
        if (y !== '0) begin n_fail++; $display("FAIL reset_y got=%0d exp=0", y); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] vals [5] = '{8'd0, 8'd1, 8'd5, 8'd7, 8'd255};
        int bc; bit mv; logic [3*WIDTH-1:0] yf;
        for (int i = 0; i < 5; i++) begin
            run_op(vals[i], -1, '0, bc, mv, yf);
            n_checks++;
            if (yf !== 24'(cube_model(longint'(vals[i])))) begin
                n_fail++; $display("FAIL directed_y a=%0d got=%0d exp=%0d", vals[i], yf, cube_model(longint'(vals[i])));
            end
            n_checks++;
            if (bc != LAT) begin n_fail++; $display("FAIL directed_latency a=%0d got=%0d exp=%0d", vals[i], bc, LAT); end
            n_checks++;
            if (mv) begin n_fail++; $display("FAIL directed_y_hold a=%0d got=moved exp=stable", vals[i]); end
        end
    endtask

    task automatic test_ignore_start;
        int bc; bit mv; logic [3*WIDTH-1:0] yf;
        run_op(8'd3, 4, 8'd9, bc, mv, yf);
        n_checks++;
        if (yf !== 24'd27) begin n_fail++; $display("FAIL ignore_start_y got=%0d exp=27", yf); end
        n_checks++;
        if (bc != LAT) begin n_fail++; $display("FAIL ignore_start_latency got=%0d exp=%0d", bc, LAT); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_no_restart got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int bc; bit mv; logic [3*WIDTH-1:0] yf;
        @(negedge clk);
        a = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got=%0b exp=0", busy); end
        n_checks++;
        if (y !== '0) begin n_fail++; $display("FAIL reset_mid_y got=%0d exp=0", y); end
        run_op(8'd2, -1, '0, bc, mv, yf);
        n_checks++;
        if (yf !== 24'd8) begin n_fail++; $display("FAIL reset_mid_restart got=%0d exp=8", yf); end
        n_checks++;
        if (bc != LAT) begin n_fail++; $display("FAIL reset_mid_latency got=%0d exp=%0d", bc, LAT); end
    endtask

    task automatic test_back_to_back;
        int bc, low;
        bit mv;
        @(negedge clk);
        a = 8'd4; start = 1'b1;
        @(negedge clk);
        a = 8'd6;
        bc = 0;
        while (busy && bc < 200) begin bc++; @(negedge clk); end
        n_checks++;
        if (bc != LAT) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=%0d", bc, LAT); end
        n_checks++;
        if (y !== 24'd64) begin n_fail++; $display("FAIL b2b_first_y got=%0d exp=64", y); end
        low = 0;
        while (!busy && low < 10) begin low++; @(negedge clk); end
        start = 1'b0;
        n_checks++;
        if (low != 1) begin n_fail++; $display("FAIL b2b_idle_gap got=%0d exp=1", low); end
        bc = 0; mv = 1'b0;
        while (busy && bc < 200) begin
            bc++;
            if (y !== 24'd64) mv = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (mv) begin n_fail++; $display("FAIL b2b_hold_prev got=moved exp=64"); end
        n_checks++;
        if (y !== 24'd216) begin n_fail++; $display("FAIL b2b_second_y got=%0d exp=216", y); end
        n_checks++;
        if (bc != LAT) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=%0d", bc, LAT); end
    endtask

    task automatic test_random;
        int bc; bit mv; logic [3*WIDTH-1:0] yf;
        logic [WIDTH-1:0] av;
        for (int i = 0; i < 24; i++) begin
            av = WIDTH'($urandom_range(0, 255));
            run_op(av, int'($urandom_range(1, 20)), WIDTH'($urandom), bc, mv, yf);
            n_checks++;
            if (yf !== 24'(cube_model(longint'(av))) || bc != LAT || mv) begin
                n_fail++;
                $display("FAIL random a=%0d got_y=%0d exp_y=%0d got_lat=%0d exp_lat=%0d moved=%0b",
                         av, yf, cube_model(longint'(av)), bc, LAT, mv);
            end
        end
    endtask

    task automatic test_round_trip;
        int bc; bit mv; logic [3*WIDTH-1:0] yf;
        int bad = 0;
        for (int v = 0; v < 256; v++) begin
            run_op(WIDTH'(v), -1, '0, bc, mv, yf);
            n_checks++;
            if (cbrt_model(longint'(yf)) != longint'(v) || yf !== 24'(cube_model(longint'(v)))) begin
                n_fail++; bad++;
                if (bad < 8) $display("FAIL round_trip a=%0d got_y=%0d got_root=%0d exp_root=%0d",
                                      v, yf, cbrt_model(longint'(yf)), v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
